// File: rtl/bp_fpga_host_uart_rx.sv
// UART receiver feeding the FPGA host's NBF byte assembler.
// Serial bits arrive on rx_i and pass through a 2-flop synchronizer.
// A mid-bit sampling FSM then rebuilds each frame.
// A good word goes into a 1-entry output register with a v/yumi handshake.
// A bad word is dropped, and its failure is reported as a 1-cycle strobe.
//
// Ports:
//   clk_i         system clock
//   reset_n_i     synchronous reset, active low
//   rx_i          asynchronous serial input, idle high
//   data_o        received word, LSB = first bit on the wire
//   v_o           data_o valid
//   yumi_i        consumer takes data_o (only while v_o=1)
//   parity_err_o  pulse: parity mismatch, word dropped
//   frame_err_o   pulse: stop bit sampled low, word dropped
//   overrun_o     pulse: good word arrived while buffer full, new word dropped
module bp_fpga_host_uart_rx #(
   parameter int unsigned clk_per_bit_p = 10416,
   parameter int unsigned data_bits_p   = 8,
   parameter int unsigned parity_bit_p  = 0,
   parameter int unsigned parity_odd_p  = 0,
   parameter int unsigned stop_bits_p   = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   rx_i,
   output logic [data_bits_p-1:0] data_o,
   output logic                   v_o,
   input  logic                   yumi_i,
   output logic                   parity_err_o,
   output logic                   frame_err_o,
   output logic                   overrun_o
);

   localparam int unsigned CntW   = $clog2(clk_per_bit_p);
   localparam int unsigned IdxMax = (data_bits_p > stop_bits_p) ? data_bits_p : stop_bits_p;
   localparam int unsigned IdxW   = $clog2(IdxMax);

   localparam logic [CntW-1:0] CntMax   = CntW'(clk_per_bit_p - 1);
   localparam logic [CntW-1:0] CntHalf  = CntW'(clk_per_bit_p / 2 - 1);
   localparam logic [IdxW-1:0] DataLast = IdxW'(data_bits_p - 1);
   localparam logic [IdxW-1:0] StopLast = IdxW'(stop_bits_p - 1);
   localparam logic            ParOdd   = (parity_odd_p != 0);
   localparam bit              HasPar   = (parity_bit_p != 0);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop, StBreak, StDone
   } state_e;

   state_e                 state_q, state_d;
   logic                   rx_meta_q, rx_s_q;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [data_bits_p-1:0] shift_q, shift_d;
   logic                   par_ok_q, par_ok_d;
   logic [data_bits_p-1:0] data_q, data_d;
   logic                   v_q, v_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         // Sync flops preset to the idle level so reset never looks like a start bit.
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_ok_q  <= 1'b1;
         data_q    <= '0;
         v_q       <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_ok_q  <= par_ok_d;
         data_q    <= data_d;
         v_q       <= v_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      data_d   = data_q;
      v_d      = v_q & ~yumi_i;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               idx_d = '0;
               // A start bit that is gone by mid-bit was a glitch.
               state_d = rx_s_q ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_q == CntMax) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 1'b1;
               if (idx_q == DataLast) begin
                  idx_d    = '0;
                  par_ok_d = 1'b1;
                  state_d  = HasPar ? StParity : StStop;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StParity: begin
            if (cnt_q == CntMax) begin
               cnt_d    = '0;
               idx_d    = '0;
               par_ok_d = ((^shift_q) ^ rx_s_q) == ParOdd;
               state_d  = StStop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == CntMax) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end else if (idx_q == StopLast) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBreak: begin
            if (rx_s_q) state_d = StIdle;
         end
         StDone: begin
            state_d = StIdle;
            if (!par_ok_q) begin
               perr_d = 1'b1;
            end else if (v_q && !yumi_i) begin
               ovr_d = 1'b1;
            end else begin
               // A same-cycle yumi frees the slot, so the new word replaces the old one.
               data_d = shift_q;
               v_d    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_o       = data_q;
   assign v_o          = v_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;

   yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);

endmodule

// File: tb/tb_bp_fpga_host_uart_rx.sv
// Bench for bp_fpga_host_uart_rx.
// It drives an 8N1 instance and an 8E1 instance, both at 16 clocks per bit.
// Expected words go into per-instance queues when a frame is sent.
// A monitor pops and compares a word on each accepted handshake.
module tb_bp_fpga_host_uart_rx;

   localparam int Cpb = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_n1 = 1'b1, rx_e1 = 1'b1;
   logic [7:0] data_n1, data_e1;
   logic       v_n1, v_e1, yumi_n1, yumi_e1;
   logic       perr_n1, ferr_n1, ovr_n1, perr_e1, ferr_e1, ovr_e1;
   logic       ack_en = 1'b1;

   int compared = 0;
   int mismatched = 0;
   int perr_n1_cnt = 0, ferr_n1_cnt = 0, ovr_n1_cnt = 0;
   int perr_e1_cnt = 0, ferr_e1_cnt = 0, ovr_e1_cnt = 0;
   logic [7:0] q_n1[$];
   logic [7:0] q_e1[$];

   always #5 clk = ~clk;

   assign yumi_n1 = ack_en & v_n1;
   assign yumi_e1 = v_e1;

   bp_fpga_host_uart_rx #(
      .clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(1)
   ) u_n1 (
      .clk_i(clk), .reset_n_i(rst_n), .rx_i(rx_n1), .data_o(data_n1), .v_o(v_n1),
      .yumi_i(yumi_n1), .parity_err_o(perr_n1), .frame_err_o(ferr_n1), .overrun_o(ovr_n1)
   );

   bp_fpga_host_uart_rx #(
      .clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bit_p(1), .parity_odd_p(0), .stop_bits_p(1)
   ) u_e1 (
      .clk_i(clk), .reset_n_i(rst_n), .rx_i(rx_e1), .data_o(data_e1), .v_o(v_e1),
      .yumi_i(yumi_e1), .parity_err_o(perr_e1), .frame_err_o(ferr_e1), .overrun_o(ovr_e1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (perr_n1) perr_n1_cnt++;
      if (ferr_n1) ferr_n1_cnt++;
      if (ovr_n1)  ovr_n1_cnt++;
      if (perr_e1) perr_e1_cnt++;
      if (ferr_e1) ferr_e1_cnt++;
      if (ovr_e1)  ovr_e1_cnt++;
   end

   always @(negedge clk) begin
      if (v_n1 && yumi_n1) begin
         if (q_n1.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL n1_unexpected: observed 0x%0h expected no word", data_n1);
         end else begin
            chk("n1_data", 32'(data_n1), 32'(q_n1.pop_front()));
         end
      end
      if (v_e1 && yumi_e1) begin
         if (q_e1.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL e1_unexpected: observed 0x%0h expected no word", data_e1);
         end else begin
            chk("e1_data", 32'(data_e1), 32'(q_e1.pop_front()));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_bit(input bit sel_e1, input logic b);
      if (sel_e1) rx_e1 = b;
      else rx_n1 = b;
      wait_cyc(Cpb);
   endtask

   // Leaves the line at the stop level when the frame ends.
   task automatic send(input bit sel_e1, input logic [7:0] d, input bit has_par, input logic p,
                       input logic stop);
      put_bit(sel_e1, 1'b0);
      for (int i = 0; i < 8; i++) put_bit(sel_e1, d[i]);
      if (has_par) put_bit(sel_e1, p);
      put_bit(sel_e1, stop);
   endtask

   initial begin
      wait_cyc(4);
      rst_n = 1'b1;
      wait_cyc(1);
      chk("rst_v_n1", 32'(v_n1), 0);
      chk("rst_data_n1", 32'(data_n1), 0);
      chk("rst_v_e1", 32'(v_e1), 0);
      chk("rst_pulses", 32'({perr_n1, ferr_n1, ovr_n1, perr_e1, ferr_e1, ovr_e1}), 0);

      // 8N1 back-to-back frames, consumer always ready
      q_n1.push_back(8'hA5);
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      q_n1.push_back(8'h3C);
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      chk("t1_q_drained", q_n1.size(), 0);
      chk("t1_no_err", perr_n1_cnt + ferr_n1_cnt + ovr_n1_cnt, 0);

      // 8E1: good parity, then bad parity
      q_e1.push_back(8'h07);
      send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      wait_cyc(20);
      chk("t2_q_drained", q_e1.size(), 0);
      send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      wait_cyc(20);
      chk("t2_perr_once", perr_e1_cnt, 1);
      chk("t2_v_low", 32'(v_e1), 0);
      chk("t2_other_err", ferr_e1_cnt + ovr_e1_cnt, 0);

      // Stop bit low, line held low, then a good frame
      send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      wait_cyc(100);
      rx_n1 = 1'b1;
      wait_cyc(20);
      chk("t3_ferr_once", ferr_n1_cnt, 1);
      chk("t3_v_low", 32'(v_n1), 0);
      q_n1.push_back(8'h11);
      send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      chk("t3_q_drained", q_n1.size(), 0);

      // Short low glitch is a false start
      rx_n1 = 1'b0;
      wait_cyc(5);
      rx_n1 = 1'b1;
      wait_cyc(40);
      chk("t4_v_low", 32'(v_n1), 0);
      chk("t4_no_err", perr_n1_cnt + ferr_n1_cnt + ovr_n1_cnt, 1);

      // Overrun while the consumer stalls
      ack_en = 1'b0;
      q_n1.push_back(8'h01);
      send(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      wait_cyc(10);
      chk("t5_v_held", 32'(v_n1), 1);
      chk("t5_data_held", 32'(data_n1), 32'h01);
      chk("t5_ovr_once", ovr_n1_cnt, 1);
      ack_en = 1'b1;
      wait_cyc(5);
      chk("t5_v_after_yumi", 32'(v_n1), 0);
      chk("t5_q_drained", q_n1.size(), 0);
      q_n1.push_back(8'h03);
      send(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      chk("t5_q3_drained", q_n1.size(), 0);

      // Reset during data bit 4 of 0xF0; the rest of that frame is idle-high
      put_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) put_bit(1'b0, 1'b0);
      rx_n1 = 1'b1;
      wait_cyc(8);
      rst_n = 1'b0;
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(8 + 4 * Cpb);
      chk("t6_v_low", 32'(v_n1), 0);
      chk("t6_no_new_err", perr_n1_cnt + ferr_n1_cnt + ovr_n1_cnt, 2);
      q_n1.push_back(8'h5A);
      send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      chk("t6_q_drained", q_n1.size(), 0);
      chk("t6_no_err_after", perr_n1_cnt + ferr_n1_cnt + ovr_n1_cnt, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
